// File: rtl/tpu_stream_core_if.sv
// rtl/tpu_stream_core_if.sv - pin-level byte stream bundle for tpu_stream_core
interface tpu_stream_core_if;
    logic [7:0] din;
    logic       wr;
    logic       rd;
    logic       acc;
    logic       clr;
    logic [7:0] dout;
    logic       dout_valid;
    logic       res_ready;
    logic       busy;

    modport master (
        output din, wr, rd, acc, clr,
        input  dout, dout_valid, res_ready, busy
    );

    modport slave (
        input  din, wr, rd, acc, clr,
        output dout, dout_valid, res_ready, busy
    );
endinterface

// File: rtl/tpu_stream_core.sv
// rtl/tpu_stream_core.sv - byte-serial NxN matrix multiply/accumulate core; TPU_STREAM_SATURATE_EN selects saturating accumulate
module tpu_stream_core #(
    parameter int N        = 2,
    parameter int EW       = 4,
    parameter int AW       = 12,
    parameter int OUT_HOLD = 6
) (
    input  logic             clk,
    input  logic             rst,
    tpu_stream_core_if.slave bus
);
    localparam int NN = N * N;
    localparam int IW = $clog2(N);
    localparam int LW = $clog2(NN);
    localparam int PW = 2 * EW + $clog2(N);
    localparam int NB = (AW + 7) / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int HW = (OUT_HOLD > 1) ? $clog2(OUT_HOLD) : 1;

    localparam logic [IW-1:0] LAST_N    = IW'(N - 1);
    localparam logic [LW-1:0] LAST_E    = LW'(NN - 1);
    localparam logic [BW-1:0] LAST_B    = BW'(NB - 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(OUT_HOLD - 1);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, READY} state_t;

    state_t state, state_n;

    // Strobe bits packed as {clr, acc, rd, wr}
    logic [3:0] s1, s2, s3, edge_p;
    logic       clr_p, acc_p, rd_p, wr_p;

    logic [LW-1:0] ld_idx, e_idx;
    logic [IW-1:0] i_c, j_c, k_c;
    logic [BW-1:0] b_idx;
    logic [HW-1:0] hold_cnt;
    logic [PW-1:0] psum;
    logic          acc_mode, res_ready, dout_valid;
    logic [7:0]    dout;

    logic [EW-1:0] a_mem [NN];
    logic [EW-1:0] b_mem [NN];
    logic [AW-1:0] acc_mem [NN];

    logic [LW-1:0]     a_idx, bm_idx, c_idx;
    logic [2*EW-1:0]   prod;
    logic [PW-1:0]     sum;
    logic [AW-1:0]     commit_ext, acc_new, commit_val;
    logic [AW:0]       acc_sum;
    logic [NB*8-1:0]   out_word, out_shift;
    logic [7:0]        out_byte;
    logic              last_mac, rd_take, hold_done, ld_last;
    logic              unused_din;

    assign unused_din = ^bus.din;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= {bus.clr, bus.acc, bus.rd, bus.wr};
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_p = s2 & ~s3;
    assign clr_p  = edge_p[3];
    assign acc_p  = edge_p[2] & ~clr_p;
    assign rd_p   = edge_p[1] & ~clr_p;
    assign wr_p   = edge_p[0] & ~clr_p;

    always_comb begin
        a_idx      = LW'(i_c) * LW'(N) + LW'(k_c);
        bm_idx     = LW'(k_c) * LW'(N) + LW'(j_c);
        c_idx      = LW'(i_c) * LW'(N) + LW'(j_c);
        prod       = {{EW{1'b0}}, a_mem[a_idx]} * {{EW{1'b0}}, b_mem[bm_idx]};
        sum        = ((k_c == '0) ? '0 : psum) + PW'(prod);
        commit_ext = AW'(sum);
        acc_sum    = {1'b0, acc_mem[c_idx]} + {1'b0, commit_ext};
`ifdef TPU_STREAM_SATURATE_EN
        acc_new    = acc_sum[AW] ? '1 : acc_sum[AW-1:0];
`else
        acc_new    = acc_sum[AW-1:0];
`endif
        commit_val = acc_mode ? acc_new : commit_ext;
        last_mac   = (i_c == LAST_N) && (j_c == LAST_N) && (k_c == LAST_N);
        out_word   = (NB*8)'(acc_mem[e_idx]);
        out_shift  = out_word >> {b_idx, 3'b000};
        out_byte   = out_shift[7:0];
        rd_take    = rd_p && res_ready && !dout_valid;
        hold_done  = dout_valid && (hold_cnt == '0);
        ld_last    = (ld_idx == LAST_E);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LOAD_A;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (clr_p) begin
            state_n = LOAD_A;
        end else begin
            case (state)
                LOAD_A:  if (wr_p && ld_last) state_n = LOAD_B;
                LOAD_B:  if (wr_p && ld_last) state_n = COMPUTE;
                COMPUTE: if (last_mac) state_n = READY;
                READY:   if (!res_ready && hold_done) state_n = LOAD_A;
                default: state_n = LOAD_A;
            endcase
        end
    end

    // Operand storage needs no reset: it is always rewritten before COMPUTE reads it
    always_ff @(posedge clk) begin
        if (wr_p && state == LOAD_A) a_mem[ld_idx] <= bus.din[EW-1:0];
        if (wr_p && state == LOAD_B) b_mem[ld_idx] <= bus.din[EW-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_idx     <= '0;
            e_idx      <= '0;
            i_c        <= '0;
            j_c        <= '0;
            k_c        <= '0;
            b_idx      <= '0;
            hold_cnt   <= '0;
            psum       <= '0;
            acc_mode   <= 1'b0;
            res_ready  <= 1'b0;
            dout_valid <= 1'b0;
            dout       <= '0;
            for (int e = 0; e < NN; e++) acc_mem[e] <= '0;
        end else if (clr_p) begin
            ld_idx     <= '0;
            e_idx      <= '0;
            i_c        <= '0;
            j_c        <= '0;
            k_c        <= '0;
            b_idx      <= '0;
            hold_cnt   <= '0;
            psum       <= '0;
            acc_mode   <= 1'b0;
            res_ready  <= 1'b0;
            dout_valid <= 1'b0;
            for (int e = 0; e < NN; e++) acc_mem[e] <= '0;
        end else begin
            if (acc_p) acc_mode <= 1'b1;
            case (state)
                LOAD_A, LOAD_B: begin
                    if (wr_p) ld_idx <= ld_last ? '0 : ld_idx + LW'(1);
                end
                COMPUTE: begin
                    psum <= sum;
                    if (k_c == LAST_N) begin
                        k_c            <= '0;
                        acc_mem[c_idx] <= commit_val;
                        if (j_c == LAST_N) begin
                            j_c <= '0;
                            i_c <= (i_c == LAST_N) ? '0 : i_c + IW'(1);
                        end else begin
                            j_c <= j_c + IW'(1);
                        end
                    end else begin
                        k_c <= k_c + IW'(1);
                    end
                    if (last_mac) res_ready <= 1'b1;
                end
                READY: begin
                    if (rd_take) begin
                        dout       <= out_byte;
                        dout_valid <= 1'b1;
                        hold_cnt   <= HOLD_INIT;
                        if (b_idx == LAST_B) begin
                            b_idx <= '0;
                            if (e_idx == LAST_E) begin
                                e_idx     <= '0;
                                res_ready <= 1'b0;
                            end else begin
                                e_idx <= e_idx + LW'(1);
                            end
                        end else begin
                            b_idx <= b_idx + BW'(1);
                        end
                    end else if (dout_valid) begin
                        if (hold_cnt == '0) dout_valid <= 1'b0;
                        else                hold_cnt   <= hold_cnt - HW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.dout       = dout;
    assign bus.dout_valid = dout_valid;
    assign bus.res_ready  = res_ready;
    assign bus.busy       = (state == COMPUTE);
endmodule

// File: tb/tb_tpu_stream_core.sv
// tb/tb_tpu_stream_core.sv - directed and randomized bench for tpu_stream_core against a matrix-level model
module tb_tpu_stream_core;
    localparam int N        = 2;
    localparam int EW       = 4;
    localparam int AW       = 12;
    localparam int OUT_HOLD = 6;
    localparam int NN       = N * N;
    localparam int NB       = (AW + 7) / 8;
    localparam int EMASK    = (1 << EW) - 1;
    localparam int AMAX     = (1 << AW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tpu_stream_core_if bus();

    tpu_stream_core #(.N(N), .EW(EW), .AW(AW), .OUT_HOLD(OUT_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks      = 0;
    int errors      = 0;
    int busy_cycles = 0;
    int m_acc [NN];
    bit m_mode;
    int ma [NN];
    int mb [NN];

    always @(negedge clk) if (bus.busy === 1'b1) busy_cycles++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input bit do_clr, input bit do_acc);
        bus.clr = do_clr;
        bus.acc = do_acc;
        repeat (3) @(negedge clk);
        bus.clr = 1'b0;
        bus.acc = 1'b0;
        repeat (3) @(negedge clk);
        if (do_clr) begin
            m_mode = 1'b0;
            for (int e = 0; e < NN; e++) m_acc[e] = 0;
        end else if (do_acc) begin
            m_mode = 1'b1;
        end
    endtask

    task automatic write_byte(input logic [7:0] v);
        bus.din = v;
        bus.wr  = 1'b1;
        repeat (3) @(negedge clk);
        bus.wr  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic model_run(input int a [NN], input int b [NN]);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int s = 0;
                for (int k = 0; k < N; k++)
                    s += (a[i*N+k] & EMASK) * (b[k*N+j] & EMASK);
                if (m_mode) begin
                    int t = m_acc[i*N+j] + s;
`ifdef TPU_STREAM_SATURATE_EN
                    if (t > AMAX) t = AMAX;
`else
                    t = t % (AMAX + 1);
`endif
                    m_acc[i*N+j] = t;
                end else begin
                    m_acc[i*N+j] = s;
                end
            end
    endtask

    task automatic compute_wait(input string tag, input bit spam);
        int c = 0;
        while (bus.res_ready !== 1'b1 && c < 200) begin
            @(negedge clk);
            if (spam && bus.busy === 1'b1) bus.wr = ~bus.wr;
            c++;
        end
        bus.wr = 1'b0;
        chk({tag, "_ready"}, bus.res_ready, 1);
        chk({tag, "_busy_cycles"}, busy_cycles, N * N * N);
    endtask

    task automatic read_run(input string tag, input bit dbl);
        for (int n = 0; n < NN * NB; n++) begin
            bit         seen = 1'b0;
            int         vc   = 0;
            logic [7:0] got  = '0;
            logic [7:0] last = '0;
            int         exp_b = (m_acc[n / NB] >> (8 * (n % NB))) & 255;
            bus.rd = 1'b1;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                if (c == 2) bus.rd = 1'b0;
                if (dbl && n == 0 && c == 4) bus.rd = 1'b1;
                if (dbl && n == 0 && c == 6) bus.rd = 1'b0;
                if (bus.dout_valid === 1'b1) begin
                    if (!seen) got = bus.dout;
                    seen = 1'b1;
                    vc++;
                    last = bus.dout;
                end else if (seen) begin
                    break;
                end
            end
            chk($sformatf("%s_byte%0d", tag, n), got, exp_b);
            chk($sformatf("%s_hold%0d", tag, n), vc, OUT_HOLD);
            if (dbl && n == 0) chk({tag, "_hold_same"}, last, got);
            repeat (3) @(negedge clk);
        end
        chk({tag, "_ready_low"}, bus.res_ready, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input int a [NN], input int b [NN], input string tag,
                       input bit spam, input bit dbl);
        busy_cycles = 0;
        for (int e = 0; e < NN; e++) write_byte(8'(a[e]));
        for (int e = 0; e < NN; e++) write_byte(8'(b[e]));
        compute_wait(tag, spam);
        model_run(a, b);
        read_run(tag, dbl);
    endtask

    initial begin
        bit seen;
        int c;
        bus.din = '0;
        bus.wr  = 1'b0;
        bus.rd  = 1'b0;
        bus.acc = 1'b0;
        bus.clr = 1'b0;
        m_mode  = 1'b0;
        for (int e = 0; e < NN; e++) m_acc[e] = 0;

        repeat (3) @(negedge clk);
        chk("reset_dout", bus.dout, 0);
        chk("reset_dout_valid", bus.dout_valid, 0);
        chk("reset_res_ready", bus.res_ready, 0);
        chk("reset_busy", bus.busy, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        seen = 1'b0;
        bus.rd = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 3) bus.rd = 1'b0;
            if (bus.dout_valid === 1'b1) seen = 1'b1;
        end
        chk("early_rd_valid", seen, 0);
        chk("early_rd_dout", bus.dout, 0);

        ma = '{1, 2, 3, 4};
        mb = '{5, 6, 7, 8};
        run(ma, mb, "basic", 1'b1, 1'b1);

        strobe(1'b0, 1'b1);
        run(ma, mb, "accum", 1'b0, 1'b0);

        for (int e = 0; e < NN; e++) write_byte(8'(ma[e]));
        write_byte(8'hAA);
        write_byte(8'h55);
        strobe(1'b1, 1'b1);
        run(ma, mb, "clr_prec", 1'b0, 1'b0);

        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b1);
        ma = '{255, 255, 255, 255};
        mb = '{255, 255, 255, 255};
        for (int r = 0; r < 10; r++) run(ma, mb, $sformatf("sat%0d", r), 1'b0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            int act = $urandom_range(0, 2);
            if (act == 1) strobe(1'b0, 1'b1);
            if (act == 2) strobe(1'b1, 1'b0);
            for (int e = 0; e < NN; e++) begin
                ma[e] = $urandom_range(0, 255);
                mb[e] = $urandom_range(0, 255);
            end
            run(ma, mb, $sformatf("rand%0d", r), r[0], 1'b0);
        end

        busy_cycles = 0;
        for (int e = 0; e < 2 * NN; e++) write_byte(8'($urandom_range(0, 255)));
        c = 0;
        while (busy_cycles < 4 && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("rst_mid_reached", (busy_cycles >= 4), 1);
        rst = 1'b0;
        #1;
        chk("rst_mid_dout", bus.dout, 0);
        chk("rst_mid_dout_valid", bus.dout_valid, 0);
        chk("rst_mid_res_ready", bus.res_ready, 0);
        chk("rst_mid_busy", bus.busy, 0);
        m_mode = 1'b0;
        for (int e = 0; e < NN; e++) m_acc[e] = 0;
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.res_ready === 1'b1) seen = 1'b1;
        end
        chk("rst_mid_no_ready", seen, 0);
        ma = '{0, 0, 0, 0};
        mb = '{0, 0, 0, 0};
        run(ma, mb, "after_rst", 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
